common_sync_bus: RTL

- Parametrised multi-bit, multi-stage CDC level synchroniser. It generalises the team's 2-FF single-bit synchroniser.
- Each of WIDTH independent single-bit channels passes through STAGES flip-flops into a registered output stage.
- Each channel generates registered rise/fall pulses in the destination domain.
- An optional per-channel glitch filter (debounce counter) can be compiled in.
- Used on asynchronous control/status inputs (pad strobes, mode pins, slow-domain flags) entering the core clock domain.

---
 rtl/common_sync_bus.sv | 105 ++++++++++
 1 files changed

// File: rtl/common_sync_bus.sv
// Multi-bit, multi-stage level synchroniser with registered rise/fall pulses per channel.
// Define COMMON_SYNC_FILT_EN to add a per-channel debounce filter of FILT_LEN cycles.

module common_sync_bus_lane #(
  parameter int   NSTG     = 2,
  parameter logic RST      = 1'b0,
  parameter int   FILT_LEN = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic chg_nxt_o
);

  (* keep = "true", ASYNC_REG = "TRUE" *) logic [NSTG-1:0] s;
  logic s_out;
  logic nxt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) s <= {NSTG{RST}};
    else         s <= {s[NSTG-2:0], d_i};
  end

  assign s_out = s[NSTG-1];

`ifdef COMMON_SYNC_FILT_EN
  localparam int CW = $clog2(FILT_LEN) + 1;
  localparam logic [CW-1:0] CMAX = CW'(FILT_LEN - 1);

  logic [CW-1:0] cnt;
  logic          hit;

  // s_out has disagreed with q_o for FILT_LEN consecutive cycles
  assign hit = (s_out != q_o) && (cnt == CMAX);
  assign nxt = hit ? s_out : q_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                   cnt <= '0;
    else if ((s_out == q_o) || hit) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end
`else
  assign nxt = s_out;
`endif

  assign chg_nxt_o = nxt ^ q_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q_o    <= RST;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      q_o    <= nxt;
      rise_o <= nxt & ~q_o;
      fall_o <= ~nxt & q_o;
    end
  end

endmodule

module common_sync_bus #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               FILT_LEN  = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);

  localparam int NSTG = (STAGES < 2) ? 2 : STAGES;

  logic [WIDTH-1:0] chg_nxt;

  for (genvar n = 0; n < WIDTH; n++) begin : g_lane
    common_sync_bus_lane #(
      .NSTG     (NSTG),
      .RST      (RESET_VAL[n]),
      .FILT_LEN (FILT_LEN)
    ) u_lane (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .d_i       (data_i[n]),
      .q_o       (data_o[n]),
      .rise_o    (rise_o[n]),
      .fall_o    (fall_o[n]),
      .chg_nxt_o (chg_nxt[n])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) change_o <= 1'b0;
    else         change_o <= |chg_nxt;
  end

endmodule
